// File: rtl/display_mode_ctrl_pkg.sv
// Shared definitions for the display-mode controller and its consumers
// (display mux, LCD block): mode encodings, LED patterns, blank values.
package display_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WATCH     = 2'b00,
    ST_STOPWATCH = 2'b01,
    ST_ALARM     = 2'b10,
    ST_RING      = 2'b11
  } mode_e;

  localparam logic [7:0] LED_WATCH    = 8'h01;
  localparam logic [7:0] LED_SW       = 8'h02;
  localparam logic [7:0] LED_ALARM    = 8'h04;
  localparam logic [7:0] LED_RING_ON  = 8'hFF;
  localparam logic [7:0] LED_RING_OFF = 8'h00;

  localparam logic [7:0] SEG_DATA_BLANK = 8'h00;
  localparam logic [7:0] SEG_COM_BLANK  = 8'hFF;

  // Mode-button rotation; RING is never rotated through.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      ST_WATCH:     return ST_STOPWATCH;
      ST_STOPWATCH: return ST_ALARM;
      default:      return ST_WATCH;
    endcase
  endfunction

  function automatic logic [7:0] mode_led(input mode_e m, input logic blink_on);
    case (m)
      ST_WATCH:     return LED_WATCH;
      ST_STOPWATCH: return LED_SW;
      ST_ALARM:     return LED_ALARM;
      default:      return blink_on ? LED_RING_ON : LED_RING_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debouncer, rising-edge pulse.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw button, asynchronous to clk
//   pulse_o    : one-cycle pulse when a 0->1 transition is accepted
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // Down-counter runs only while the synchronized input disagrees with the
  // accepted level; reaching zero on a disagreeing sample means DEBOUNCE_CYC
  // consecutive equal samples have been seen.
  assign accept = (sync2_q != level_q) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= accept & sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= CNT_LOAD;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode controller: cycles WATCH/STOPWATCH/ALARM on the mode button,
// pre-empts into RING on an alarm, and drives the registered display bus
// and mode LEDs.
// Ports:
//   clk, rst                 : 1 kHz clock, async active-low reset
//   mode_btn, ack_btn        : raw push-buttons
//   alarm_ring               : alarm compare level
//   *_seg_data / *_seg_com   : source display buses
//   seg_data, seg_com        : selected, registered display bus
//   mode_sel, ringing, led   : current mode indication
//
// state     | meaning
// ----------+------------------------------------------------
// WATCH     | time of day shown, led 01
// STOPWATCH | stopwatch shown, led 02
// ALARM     | alarm setting shown, led 04
// RING      | alarm ringing, alarm bus shown blinking, led FF/00
module display_mode_ctrl
  import display_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int BLINK_HALF   = 250,
  parameter int BLANK_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       ack_btn,
  input  logic       alarm_ring,
  input  logic [7:0] watch_seg_data,
  input  logic [7:0] watch_seg_com,
  input  logic [7:0] sw_seg_data,
  input  logic [7:0] sw_seg_com,
  input  logic [7:0] alm_seg_data,
  input  logic [7:0] alm_seg_com,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com,
  output logic [1:0] mode_sel,
  output logic       ringing,
  output logic [7:0] led
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int BLANK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC);

  logic mode_pulse, ack_pulse;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk    (clk),
    .rst_n  (rst),
    .btn_i  (mode_btn),
    .pulse_o(mode_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ack_db (
    .clk    (clk),
    .rst_n  (rst),
    .btn_i  (ack_btn),
    .pulse_o(ack_pulse)
  );

  mode_e                state_q, state_d;
  mode_e                ret_q, ret_d;
  logic                 alarm_prev_q;
  logic                 alarm_rise;
  logic                 ringing_q;
  logic [7:0]           led_q, led_d;
  logic                 blink_on_q, blink_on_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [BLANK_W-1:0]   blank_cnt_q;
  logic [7:0]           seg_data_q, seg_com_q;

  assign alarm_rise = alarm_ring & ~alarm_prev_q;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    blink_on_d  = 1'b0;
    blink_cnt_d = '0;

    case (state_q)
      ST_RING: begin
        if (ack_pulse || !alarm_ring) state_d = ret_q;
      end
      default: begin
        // The alarm takes priority; a coincident mode pulse is dropped.
        if (alarm_rise) begin
          state_d = ST_RING;
          ret_d   = state_q;
        end else if (mode_pulse) begin
          state_d = next_mode(state_q);
        end
      end
    endcase

    if (state_d == ST_RING) begin
      if (state_q != ST_RING) begin
        blink_on_d  = 1'b1;
        blink_cnt_d = BLINK_LOAD;
      end else if (blink_cnt_q == '0) begin
        blink_on_d  = ~blink_on_q;
        blink_cnt_d = BLINK_LOAD;
      end else begin
        blink_on_d  = blink_on_q;
        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
      end
    end

    led_d = mode_led(state_d, blink_on_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WATCH;
      ret_q        <= ST_WATCH;
      // Starts high so an alarm already asserted at reset release is not
      // mistaken for a fresh rising edge.
      alarm_prev_q <= 1'b1;
      ringing_q    <= 1'b0;
      led_q        <= LED_WATCH;
      blink_on_q   <= 1'b0;
      blink_cnt_q  <= '0;
      blank_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      alarm_prev_q <= alarm_ring;
      ringing_q    <= (state_d == ST_RING);
      led_q        <= led_d;
      blink_on_q   <= blink_on_d;
      blink_cnt_q  <= blink_cnt_d;
      if (state_d != state_q) begin
        blank_cnt_q <= BLANK_LOAD;
      end else if (blank_cnt_q != '0) begin
        blank_cnt_q <= blank_cnt_q - BLANK_W'(1);
      end
    end
  end

  // Display bus samples the source chosen by the current state, so the
  // output trails the source by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_data_q <= SEG_DATA_BLANK;
      seg_com_q  <= SEG_COM_BLANK;
    end else if (blank_cnt_q != '0) begin
      seg_data_q <= SEG_DATA_BLANK;
      seg_com_q  <= SEG_COM_BLANK;
    end else begin
      case (state_q)
        ST_WATCH: begin
          seg_data_q <= watch_seg_data;
          seg_com_q  <= watch_seg_com;
        end
        ST_STOPWATCH: begin
          seg_data_q <= sw_seg_data;
          seg_com_q  <= sw_seg_com;
        end
        default: begin
          seg_data_q <= alm_seg_data;
          seg_com_q  <= (state_q == ST_RING && !blink_on_q) ? SEG_COM_BLANK : alm_seg_com;
        end
      endcase
    end
  end

  assign seg_data = seg_data_q;
  assign seg_com  = seg_com_q;
  assign mode_sel = state_q;
  assign ringing  = ringing_q;
  assign led      = led_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
module tb_display_mode_ctrl;

  localparam int DB = 20;
  localparam int H  = 250;
  localparam int BL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0, ack_btn = 1'b0, alarm_ring = 1'b0;
  logic [7:0] w_d = 8'h00, w_c = 8'h00, s_d = 8'h00, s_c = 8'h00, a_d = 8'h00, a_c = 8'h00;
  logic [7:0] seg_data, seg_com, led;
  logic [1:0] mode_sel;
  logic       ringing;

  int n_chk = 0;
  int n_err = 0;

  display_mode_ctrl #(.DEBOUNCE_CYC(DB), .BLINK_HALF(H), .BLANK_CYC(BL)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_btn      (mode_btn),
    .ack_btn       (ack_btn),
    .alarm_ring    (alarm_ring),
    .watch_seg_data(w_d),
    .watch_seg_com (w_c),
    .sw_seg_data   (s_d),
    .sw_seg_com    (s_c),
    .alm_seg_data  (a_d),
    .alm_seg_com   (a_c),
    .seg_data      (seg_data),
    .seg_com       (seg_com),
    .mode_sel      (mode_sel),
    .ringing       (ringing),
    .led           (led)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0..3 (3 = ring), time stamps in clock edges.
  int         m_mode, m_ret, m_entry_n, m_change_n, m_n;
  bit         m_alarm_last;
  bit         m_h1[2], m_h2[2], m_sv[2], m_acc[2], m_pulse[2];
  int         m_sl[2];
  logic [7:0] e_sd, e_sc, e_led;
  int         e_mode;
  bit         e_ring;

  function automatic bit m_on(input int n);
    return ((n - m_entry_n) / H) % 2 == 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ret = 0; m_alarm_last = 1'b1;
    m_entry_n = 0; m_change_n = -1000;
    for (int b = 0; b < 2; b++) begin
      m_h1[b] = 0; m_h2[b] = 0; m_sv[b] = 0; m_sl[b] = 0; m_acc[b] = 0; m_pulse[b] = 0;
    end
    e_sd = 8'h00; e_sc = 8'hFF; e_led = 8'h01; e_mode = 0; e_ring = 1'b0;
  endtask

  task automatic model_edge();
    int k, old;
    bit rise, smp;
    bit btn[2];
    m_n++;
    k = m_n;
    old = m_mode;
    if (k - m_change_n >= 1 && k - m_change_n <= BL) begin
      e_sd = 8'h00; e_sc = 8'hFF;
    end else if (old == 0) begin
      e_sd = w_d; e_sc = w_c;
    end else if (old == 1) begin
      e_sd = s_d; e_sc = s_c;
    end else begin
      e_sd = a_d;
      e_sc = (old == 3 && !m_on(k - 1)) ? 8'hFF : a_c;
    end
    rise = alarm_ring && !m_alarm_last;
    if (old == 3) begin
      if (m_pulse[1] || !alarm_ring) m_mode = m_ret;
    end else if (rise) begin
      m_ret = old; m_mode = 3; m_entry_n = k;
    end else if (m_pulse[0]) begin
      m_mode = (old + 1) % 3;
    end
    if (m_mode != old) m_change_n = k;
    e_mode = m_mode;
    e_ring = (m_mode == 3);
    if (m_mode == 3) e_led = m_on(k) ? 8'hFF : 8'h00;
    else e_led = 8'(1 << m_mode);
    m_alarm_last = alarm_ring;
    btn[0] = mode_btn; btn[1] = ack_btn;
    for (int b = 0; b < 2; b++) begin
      smp = m_h2[b];
      m_h2[b] = m_h1[b];
      m_h1[b] = btn[b];
      if (smp == m_sv[b]) m_sl[b]++;
      else begin m_sv[b] = smp; m_sl[b] = 1; end
      m_pulse[b] = 0;
      if (m_sv[b] != m_acc[b] && m_sl[b] >= DB) begin
        m_acc[b] = m_sv[b];
        m_pulse[b] = m_sv[b];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("seg_data", 32'(seg_data), 32'(e_sd));
    chk("seg_com",  32'(seg_com),  32'(e_sc));
    chk("led",      32'(led),      32'(e_led));
    chk("mode_sel", 32'(mode_sel), 32'(e_mode));
    chk("ringing",  32'(ringing),  32'(e_ring));
  endtask

  task automatic step();
    w_d = 8'($urandom); w_c = 8'($urandom);
    s_d = 8'($urandom); s_c = 8'($urandom);
    a_d = 8'($urandom); a_c = 8'($urandom);
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int b, input int hold, input int rel);
    if (b == 0) mode_btn = 1'b1; else ack_btn = 1'b1;
    steps(hold);
    mode_btn = 1'b0; ack_btn = 1'b0;
    steps(rel);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_seg_data", 32'(seg_data), 32'h00);
    chk("rst_seg_com",  32'(seg_com),  32'hFF);
    chk("rst_led",      32'(led),      32'h01);
    chk("rst_mode_sel", 32'(mode_sel), 32'h0);
    chk("rst_ringing",  32'(ringing),  32'h0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int chg, r;
    logic [1:0] prev;
    bit seen;

    // Reset state
    #1;
    do_reset();
    steps(5);

    // Three clean mode presses
    for (int i = 0; i < 3; i++) begin
      press(0, 30, 30);
      chk("press_mode_sel", 32'(mode_sel), 32'((i + 1) % 3));
      chk("press_led", 32'(led), 32'(1 << ((i + 1) % 3)));
    end

    // Bouncing press: exactly one transition
    chg = 0;
    prev = mode_sel;
    for (int i = 0; i < 70; i++) begin
      if (i < 15) mode_btn = ((i / 3) % 2 == 0);
      else if (i < 40) mode_btn = 1'b1;
      else mode_btn = 1'b0;
      step();
      if (mode_sel !== prev) chg++;
      prev = mode_sel;
    end
    chk("bounce_transitions", 32'(chg), 32'd1);
    chk("bounce_mode_sel", 32'(mode_sel), 32'h1);

    // Alarm in STOPWATCH, blink timing, ack
    alarm_ring = 1'b1;
    step();
    chk("ring_entry_ringing", 32'(ringing), 32'h1);
    chk("ring_entry_mode", 32'(mode_sel), 32'h3);
    chk("ring_entry_led", 32'(led), 32'hFF);
    steps(H - 1);
    chk("ring_last_on_led", 32'(led), 32'hFF);
    step();
    chk("ring_first_off_led", 32'(led), 32'h00);
    step();
    chk("ring_off_seg_com", 32'(seg_com), 32'hFF);
    press(1, 30, 30);
    chk("ack_mode_sel", 32'(mode_sel), 32'h1);
    chk("ack_led", 32'(led), 32'h02);
    chk("ack_ringing", 32'(ringing), 32'h0);
    alarm_ring = 1'b0;
    steps(5);

    // Coincident mode pulse and alarm rise in ALARM
    press(0, 30, 30);
    chk("to_alarm_mode_sel", 32'(mode_sel), 32'h2);
    mode_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (m_pulse[0]) seen = 1'b1;
    end
    chk("coincide_pulse_seen", 32'(seen), 32'h1);
    alarm_ring = 1'b1;
    step();
    chk("coincide_ring", 32'(mode_sel), 32'h3);
    steps(5);
    mode_btn = 1'b0;
    alarm_ring = 1'b0;
    step();
    chk("coincide_return", 32'(mode_sel), 32'h2);
    steps(30);

    // Reset during RING off-phase, alarm held high afterwards
    alarm_ring = 1'b1;
    steps(H + 10);
    chk("pre_reset_led_off", 32'(led), 32'h00);
    do_reset();
    steps(20);
    chk("post_reset_ringing", 32'(ringing), 32'h0);
    chk("post_reset_mode", 32'(mode_sel), 32'h0);
    alarm_ring = 1'b0;
    steps(30);

    // Randomized traffic against the model
    for (int s = 0; s < 80; s++) begin
      r = int'($urandom_range(0, 9));
      if (s == 40) do_reset();
      if (r <= 3) begin
        press(0, int'($urandom_range(3, 40)), int'($urandom_range(25, 40)));
      end else if (r <= 5) begin
        press(1, int'($urandom_range(3, 40)), int'($urandom_range(25, 40)));
      end else if (r <= 7) begin
        alarm_ring = ~alarm_ring;
        steps(int'($urandom_range(1, 300)));
      end else if (r == 8) begin
        for (int i = 0; i < 20; i++) begin
          mode_btn = 1'($urandom);
          ack_btn = 1'($urandom);
          step();
        end
        mode_btn = 1'b0;
        ack_btn = 1'b0;
        steps(30);
      end else begin
        steps(int'($urandom_range(1, 20)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 20, meaning clk cycles a synchronized button must be stable to be accepted (20 ms at 1 kHz).
REQ-002 SHALL have parameter BLINK_HALF, default 250, meaning clk cycles per half-period of ring blink.
REQ-003 SHALL have parameter BLANK_CYC, default 2, meaning clk cycles of forced display blanking after any mode change.
REQ-004 SHALL have port clk  input  1  single system clock, 1 kHz.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode_btn  input  1  raw mode push-button, active high, asynchronous to clk.
REQ-007 SHALL have port ack_btn  input  1  raw alarm-acknowledge push-button, active high, asynchronous to clk.
REQ-008 SHALL have port alarm_ring  input  1  level from alarm datapath, high while alarm time matches.
REQ-009 SHALL have ports watch_seg_data/watch_seg_com, sw_seg_data/sw_seg_com, alm_seg_data/alm_seg_com  input  8 each  source display buses.
REQ-010 SHALL have ports seg_data  output  8  and seg_com  output  8  selected, registered display bus.
REQ-011 SHALL have port mode_sel  output  2  current state encoding, for the LCD and other consumers.
REQ-012 SHALL have port ringing  output  1  high while in RING state.
REQ-013 SHALL have port led  output  8  mode indicator / ring blink.

Function
REQ-014 SHALL pass mode_btn and ack_btn each through a 2-flop synchronizer, then a debouncer that updates the accepted level only after DEBOUNCE_CYC consecutive equal samples; an accepted 0->1 transition SHALL produce a one-cycle pulse.
REQ-015 SHALL implement FSM states WATCH=00, STOPWATCH=01, ALARM=10, RING=11.
REQ-016 On a mode pulse: WATCH->STOPWATCH->ALARM->WATCH; in RING, mode pulses SHALL be ignored.
REQ-017 On a rising edge of alarm_ring (registered compare) in any non-RING state: next state RING, with the current state saved as return state.
REQ-018 In RING: an ack pulse, or alarm_ring low, SHALL return to the saved state on the next cycle.
REQ-019 Mode pulse and alarm_ring rising edge in the same cycle: RING wins, saved state is the pre-pulse state, the mode pulse is dropped.
REQ-020 Ack pulse outside RING SHALL have no effect.
REQ-021 seg_data/seg_com SHALL be registered: output equals the selected source sampled 1 cycle earlier (WATCH->watch, STOPWATCH->sw, ALARM and RING->alm).
REQ-022 For BLANK_CYC cycles starting the cycle after any state change, seg_data SHALL be 8'h00 and seg_com 8'hFF.
REQ-023 In RING, during blink-off phase, seg_com SHALL be 8'hFF; blink phase starts "on" at RING entry and toggles every BLINK_HALF cycles.
REQ-024 led SHALL be 8'h01/8'h02/8'h04 in WATCH/STOPWATCH/ALARM; in RING 8'hFF on-phase, 8'h00 off-phase.
REQ-025 mode_sel and ringing SHALL be registered and change in the same cycle as the state register.

Reset
REQ-026 On rst low, asynchronously: state WATCH, saved state WATCH, seg_data 8'h00, seg_com 8'hFF, led 8'h01, mode_sel 2'b00, ringing 0, debouncers accept level 0, counters 0.
REQ-027 Reset asserted mid-RING or mid-blank SHALL abandon it; after release, operation resumes from WATCH with no blanking and no pending pulses.

Structure
REQ-028 State encodings, LED patterns and blank value 8'h00/8'hFF SHALL live in a shared package used by the display and LCD blocks.
REQ-029 Debouncer SHALL be one sub-module, btn_debounce (sync + debounce + edge pulse), instantiated twice.

Verification
REQ-030 Reset release, 3 clean mode presses (each held 30 cycles) -> mode_sel 01, 10, 00; led 02, 04, 01; 2 blank cycles after each change.
REQ-031 Mode press bouncing 0/1 every 3 cycles for 15 cycles, then high 25 cycles -> exactly one transition, WATCH->STOPWATCH.
REQ-032 In STOPWATCH, alarm_ring rises -> RING, ringing=1, led FF for 250 cycles then 00; ack press -> back to STOPWATCH, led 02.
REQ-033 Debounced mode pulse coincident with alarm_ring rise in ALARM -> RING; after alarm_ring falls, state ALARM (not WATCH).
REQ-034 rst low for 1 cycle while in RING off-phase -> immediately seg_com FF, led 01, mode_sel 00, ringing 0; held alarm_ring high after release -> no RING (no new rising edge).
